// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, width helper, special patterns
// and the unpacked value record exchanged between the decoder and this encoder.
package posit_pkg;

  localparam int unsigned POSIT_NBITS = 32;
  localparam int unsigned POSIT_ES    = 2;
  localparam int unsigned POSIT_FW    = 32;
  localparam int unsigned POSIT_SW    = 10;

  // Number of bits needed to index v distinct positions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam logic [POSIT_NBITS-1:0] MAXPOS = {1'b0, {(POSIT_NBITS-1){1'b1}}};
  localparam logic [POSIT_NBITS-1:0] MINPOS = {{(POSIT_NBITS-1){1'b0}}, 1'b1};
  localparam logic [POSIT_NBITS-1:0] NAR    = {1'b1, {(POSIT_NBITS-1){1'b0}}};

  typedef struct packed {
    logic                       sign;
    logic signed [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0]        frac;
    logic                       zero;
    logic                       nar;
  } posit_unpacked_t;

endpackage

// File: rtl/posit_regime_shift.sv
// Combinational regime/exponent/fraction assembly for posit encoding.
// Produces the top NBITS-1 magnitude bits plus guard and sticky for rounding.
module posit_regime_shift
  import posit_pkg::*;
#(
  parameter int unsigned NBITS = POSIT_NBITS,
  parameter int unsigned ES    = POSIT_ES,
  parameter int unsigned FW    = POSIT_FW,
  parameter int unsigned SHW   = clog2(NBITS - 1 + FW + ES + 2)
) (
  input  logic             reg_pos,
  input  logic [SHW-1:0]   shamt,
  input  logic [ES-1:0]    exp_bits,
  input  logic [FW-1:0]    frac,
  output logic [NBITS-2:0] mag,
  output logic             guard,
  output logic             sticky
);

  localparam int unsigned FLDW = NBITS - 1 + FW + ES + 2;
  localparam int unsigned PAD  = FLDW - 2 - ES - FW;

  logic [FLDW-1:0] init;
  logic [FLDW-1:0] field;

  // Seed with the two-bit regime stub ("10" or "01") and arithmetic-shift it:
  // sign extension replicates the leading regime bit, so a shift of
  // (regime length - 2) yields k+1 ones then 0, or -k zeros then 1.
  always_comb begin
    init   = {reg_pos, ~reg_pos, exp_bits, frac, {PAD{1'b0}}};
    field  = $signed(init) >>> shamt;
    mag    = field[FLDW-1 -: NBITS-1];
    guard  = field[FLDW-NBITS];
    sticky = |field[FLDW-NBITS-1:0];
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage pipelined posit encoder with round-to-nearest-even.
// S1 decodes regime/range, S2 assembles the bit field, S3 rounds, clamps and
// applies sign and specials. Optional macro POSIT_ENC_INEXACT_EN adds the
// registered out_inexact flag.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int unsigned NBITS = POSIT_NBITS,
  parameter int unsigned ES    = POSIT_ES,
  parameter int unsigned FW    = POSIT_FW,
  parameter int unsigned SW    = POSIT_SW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [SW-1:0]    in_scale,
  input  logic [FW-1:0]    in_frac,
  input  logic             in_zero,
  input  logic             in_nar,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef POSIT_ENC_INEXACT_EN
  output logic             out_inexact,
`endif
  output logic [NBITS-1:0] out_posit
);

  localparam int unsigned FLDW   = NBITS - 1 + FW + ES + 2;
  localparam int unsigned SHW    = clog2(FLDW);
  localparam int          SC_LIM = (NBITS - 2) * (2 ** ES);
  localparam logic signed [SW-1:0] SC_MAX = SW'(SC_LIM);
  localparam logic signed [SW-1:0] SC_MIN = SW'(-SC_LIM);

  logic en;

  // Stage 1 registers
  logic           s1_valid_q, s1_valid_d;
  logic           s1_sign_q,  s1_sign_d;
  logic           s1_zero_q,  s1_zero_d;
  logic           s1_nar_q,   s1_nar_d;
  logic           s1_ovf_q,   s1_ovf_d;
  logic           s1_unf_q,   s1_unf_d;
  logic           s1_pos_q,   s1_pos_d;
  logic [SHW-1:0] s1_shamt_q, s1_shamt_d;
  logic [ES-1:0]  s1_exp_q,   s1_exp_d;
  logic [FW-1:0]  s1_frac_q,  s1_frac_d;

  // Stage 2 registers
  logic             s2_valid_q,  s2_valid_d;
  logic             s2_sign_q,   s2_sign_d;
  logic             s2_zero_q,   s2_zero_d;
  logic             s2_nar_q,    s2_nar_d;
  logic             s2_ovf_q,    s2_ovf_d;
  logic             s2_unf_q,    s2_unf_d;
  logic [NBITS-2:0] s2_mag_q,    s2_mag_d;
  logic             s2_guard_q,  s2_guard_d;
  logic             s2_sticky_q, s2_sticky_d;

  // Stage 3 (output) registers
  logic             out_valid_q, out_valid_d;
  logic [NBITS-1:0] out_posit_q, out_posit_d;
`ifdef POSIT_ENC_INEXACT_EN
  logic             out_inexact_q, out_inexact_d;
`endif

  logic signed [SW-1:0] scale_s;
  logic signed [SW-1:0] k;
  logic [SW-1:0]        kmag;
  logic                 ovf, unf;

  logic [NBITS-2:0] rs_mag;
  logic             rs_guard, rs_sticky;

  logic             rnd;
  logic [NBITS-1:0] sum;
  logic [NBITS-2:0] mag_c;
  logic [NBITS-1:0] word;

  // Whole pipeline advances together unless the output is stalled
  always_comb begin
    en        = ~out_valid_q | out_ready;
    in_ready  = en;
    out_valid = out_valid_q;
    out_posit = out_posit_q;
  end

`ifdef POSIT_ENC_INEXACT_EN
  assign out_inexact = out_inexact_q;
`endif

  // S1: regime index, shift amount and range flags
  always_comb begin
    scale_s = $signed(in_scale);
    k       = scale_s >>> ES;
    // For k<0 the shift is -k-1, which is exactly ~k
    kmag    = k[SW-1] ? ~k : k;
    ovf     = scale_s > SC_MAX;
    unf     = scale_s < SC_MIN;

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    s1_ovf_d   = s1_ovf_q;
    s1_unf_d   = s1_unf_q;
    s1_pos_d   = s1_pos_q;
    s1_shamt_d = s1_shamt_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_sign;
      s1_zero_d  = in_zero;
      s1_nar_d   = in_nar;
      s1_ovf_d   = ovf;
      s1_unf_d   = unf;
      s1_pos_d   = ~k[SW-1];
      s1_shamt_d = (ovf | unf) ? '0 : SHW'(kmag);
      s1_exp_d   = in_scale[ES-1:0];
      s1_frac_d  = in_frac;
    end
  end

  posit_regime_shift #(
    .NBITS (NBITS),
    .ES    (ES),
    .FW    (FW),
    .SHW   (SHW)
  ) u_regime_shift (
    .reg_pos  (s1_pos_q),
    .shamt    (s1_shamt_q),
    .exp_bits (s1_exp_q),
    .frac     (s1_frac_q),
    .mag      (rs_mag),
    .guard    (rs_guard),
    .sticky   (rs_sticky)
  );

  // S2: capture assembled magnitude with guard and sticky
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_nar_d    = s2_nar_q;
    s2_ovf_d    = s2_ovf_q;
    s2_unf_d    = s2_unf_q;
    s2_mag_d    = s2_mag_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    if (en) begin
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = s1_zero_q;
      s2_nar_d    = s1_nar_q;
      s2_ovf_d    = s1_ovf_q;
      s2_unf_d    = s1_unf_q;
      s2_mag_d    = rs_mag;
      s2_guard_d  = rs_guard;
      s2_sticky_d = rs_sticky;
    end
  end

  // S3: round to nearest even, clamp, sign, specials
  always_comb begin
    rnd = s2_guard_q & (s2_mag_q[0] | s2_sticky_q);
    sum = {1'b0, s2_mag_q} + {{(NBITS-1){1'b0}}, rnd};
    if (s2_ovf_q || sum[NBITS-1])
      mag_c = '1;
    else if (s2_unf_q || (sum == '0))
      mag_c = {{(NBITS-2){1'b0}}, 1'b1};
    else
      mag_c = sum[NBITS-2:0];
    word = {1'b0, mag_c};
    if (s2_sign_q) word = '0 - word;

    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
`ifdef POSIT_ENC_INEXACT_EN
    out_inexact_d = out_inexact_q;
`endif
    if (en) begin
      out_valid_d = s2_valid_q;
      if (s2_nar_q)
        out_posit_d = {1'b1, {(NBITS-1){1'b0}}};
      else if (s2_zero_q)
        out_posit_d = '0;
      else
        out_posit_d = word;
`ifdef POSIT_ENC_INEXACT_EN
      out_inexact_d = (s2_nar_q | s2_zero_q) ? 1'b0
                    : (s2_guard_q | s2_sticky_q | s2_ovf_q | s2_unf_q);
`endif
    end
  end

  // Pipeline state registers; reset discards all in-flight words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_ovf_q    <= 1'b0;
      s1_unf_q    <= 1'b0;
      s1_pos_q    <= 1'b0;
      s1_shamt_q  <= '0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_nar_q    <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_unf_q    <= 1'b0;
      s2_mag_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
`ifdef POSIT_ENC_INEXACT_EN
      out_inexact_q <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_nar_q    <= s1_nar_d;
      s1_ovf_q    <= s1_ovf_d;
      s1_unf_q    <= s1_unf_d;
      s1_pos_q    <= s1_pos_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_nar_q    <= s2_nar_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_unf_q    <= s2_unf_d;
      s2_mag_q    <= s2_mag_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
`ifdef POSIT_ENC_INEXACT_EN
      out_inexact_q <= out_inexact_d;
`endif
    end
  end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed self-checking bench for posit_encode_pipe (default geometry).
module tb_posit_encode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_scale;
  logic [31:0] in_frac;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;
`ifdef POSIT_ENC_INEXACT_EN
  logic        out_inexact;
  logic        last_inexact;
`endif

  int checks = 0;
  int errors = 0;

  // Stream vectors
  logic        v_sign  [8];
  int          v_scale [8];
  logic [31:0] v_frac  [8];
  logic        v_nar   [8];
  logic [31:0] v_exp   [8];

  posit_encode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef POSIT_ENC_INEXACT_EN
    .out_inexact (out_inexact),
`endif
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_scale = '0;
    in_frac  = '0;
    in_zero  = 1'b0;
    in_nar   = 1'b0;
  endtask

  task automatic encode_one(input string name, input logic s, input int scale,
                            input logic [31:0] fr, input logic z, input logic n,
                            input logic [31:0] exp);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = s;
    in_scale  = 10'(scale);
    in_frac   = fr;
    in_zero   = z;
    in_nar    = n;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive_idle();
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 3", name, lat);
    end
    checks++;
    if (out_posit !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, out_posit, exp);
    end
`ifdef POSIT_ENC_INEXACT_EN
    last_inexact = out_inexact;
`endif
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_single: got out_valid %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_posit !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_posit: got %h expected 00000000", out_posit);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    encode_one("one",      1'b0,  0, 32'h0, 1'b0, 1'b0, 32'h4000_0000);
    encode_one("scale_p1", 1'b0,  1, 32'h0, 1'b0, 1'b0, 32'h4800_0000);
    encode_one("scale_m1", 1'b0, -1, 32'h0, 1'b0, 1'b0, 32'h3800_0000);
    encode_one("neg_one",  1'b1,  0, 32'h0, 1'b0, 1'b0, 32'hC000_0000);
    encode_one("scale_p4", 1'b0,  4, 32'h0, 1'b0, 1'b0, 32'h6000_0000);
    encode_one("scale_m4", 1'b0, -4, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
  endtask

  task automatic test_rounding();
    encode_one("tie_even",  1'b0, 0, 32'h0000_0010, 1'b0, 1'b0, 32'h4000_0000);
    encode_one("tie_odd",   1'b0, 0, 32'h0000_0030, 1'b0, 1'b0, 32'h4000_0002);
`ifdef POSIT_ENC_INEXACT_EN
    checks++;
    if (last_inexact !== 1'b1) begin
      errors++;
      $display("FAIL inexact_tie_odd: got %b expected 1", last_inexact);
    end
`endif
    encode_one("above_tie", 1'b0, 0, 32'h0000_0011, 1'b0, 1'b0, 32'h4000_0001);
    encode_one("neg_round", 1'b1, 0, 32'h0000_0030, 1'b0, 1'b0, 32'hBFFF_FFFE);
    encode_one("carry_reg", 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h4800_0000);
    encode_one("exact_one", 1'b0, 0, 32'h0,         1'b0, 1'b0, 32'h4000_0000);
`ifdef POSIT_ENC_INEXACT_EN
    checks++;
    if (last_inexact !== 1'b0) begin
      errors++;
      $display("FAIL inexact_exact: got %b expected 0", last_inexact);
    end
`endif
  endtask

  task automatic test_specials();
    encode_one("nar",       1'b0,    0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);
    encode_one("nar_zero",  1'b1,    0, 32'h0, 1'b1, 1'b1, 32'h8000_0000);
    encode_one("zero_neg",  1'b1,    5, 32'h1, 1'b1, 1'b0, 32'h0000_0000);
    encode_one("ovf",       1'b0,  200, 32'h0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    encode_one("ovf_edge",  1'b0,  121, 32'h0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    encode_one("maxpos",    1'b0,  120, 32'h0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    encode_one("unf",       1'b0, -200, 32'h0, 1'b0, 1'b0, 32'h0000_0001);
    encode_one("unf_neg",   1'b1, -200, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    encode_one("minpos",    1'b0, -120, 32'h0, 1'b0, 1'b0, 32'h0000_0001);
  endtask

  task automatic load_vec(input int i);
    in_sign  = v_sign[i];
    in_scale = 10'(v_scale[i]);
    in_frac  = v_frac[i];
    in_zero  = 1'b0;
    in_nar   = v_nar[i];
  endtask

  task automatic test_back_to_back();
    int sent, recv, cyc, extra;
    logic prev_stall;
    logic [31:0] prev_word;
    v_sign[0] = 0; v_scale[0] =    0; v_frac[0] = 32'h00; v_nar[0] = 0; v_exp[0] = 32'h4000_0000;
    v_sign[1] = 0; v_scale[1] =    1; v_frac[1] = 32'h00; v_nar[1] = 0; v_exp[1] = 32'h4800_0000;
    v_sign[2] = 0; v_scale[2] =   -1; v_frac[2] = 32'h00; v_nar[2] = 0; v_exp[2] = 32'h3800_0000;
    v_sign[3] = 1; v_scale[3] =    0; v_frac[3] = 32'h00; v_nar[3] = 0; v_exp[3] = 32'hC000_0000;
    v_sign[4] = 0; v_scale[4] =    0; v_frac[4] = 32'h30; v_nar[4] = 0; v_exp[4] = 32'h4000_0002;
    v_sign[5] = 0; v_scale[5] =    0; v_frac[5] = 32'h00; v_nar[5] = 1; v_exp[5] = 32'h8000_0000;
    v_sign[6] = 0; v_scale[6] =  200; v_frac[6] = 32'h00; v_nar[6] = 0; v_exp[6] = 32'h7FFF_FFFF;
    v_sign[7] = 1; v_scale[7] = -200; v_frac[7] = 32'h00; v_nar[7] = 0; v_exp[7] = 32'hFFFF_FFFF;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_word  = '0;
    while (recv < 8 && cyc < 300) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      drive_idle();
      if (sent < 8) begin
        in_valid = 1'b1;
        load_vec(sent);
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_posit !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: got valid %b posit %h expected valid 1 posit %h", out_valid, out_posit, prev_word);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (out_posit !== v_exp[recv]) begin
          errors++;
          $display("FAIL stream_word%0d: got %h expected %h", recv, out_posit, v_exp[recv]);
        end
        recv++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_word  = out_posit;
      cyc++;
    end
    checks++;
    if (recv != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 8", recv);
    end
    drive_idle();
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL stream_extra: got %0d extra words expected 0", extra);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      load_vec(i + 1);
      @(posedge clk);
    end
    @(negedge clk);
    drive_idle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_inflight: got out_valid %b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_posit !== 32'h0) begin
      errors++;
      $display("FAIL midreset_drop: got valid %b posit %h expected valid 0 posit 00000000", out_valid, out_posit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d words expected 0", seen);
    end
    encode_one("post_reset", 1'b0, 1, 32'h0, 1'b0, 1'b0, 32'h4800_0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
